// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: zero divisor or |a| < |b| completes in one cycle.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH:0]    bmag_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic              dz_q;

  // Operand magnitudes and result signs derived at accept time
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic              q_neg_in;
  logic              r_neg_in;
  assign a_mag    = (signed_div & a[WIDTH-1]) ? -a : a;
  assign b_mag    = (signed_div & b[WIDTH-1]) ? -b : b;
  assign q_neg_in = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign r_neg_in = signed_div & a[WIDTH-1];

  // One restoring step: shift in next dividend bit, trial-subtract |b|
  logic [WIDTH:0]    trial;
  logic              fits;
  logic [WIDTH-1:0]  sub;
  logic [WIDTH-1:0]  rem_d;
  logic [WIDTH-1:0]  quo_d;
  logic [WIDTH-1:0]  rem_fin;
  logic [WIDTH-1:0]  quo_fin;
  assign trial   = {rem_q, quo_q[WIDTH-1]};
  assign fits    = trial >= bmag_q;
  assign sub     = WIDTH'(trial - bmag_q);
  assign rem_d   = fits ? sub : trial[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], fits};
  assign rem_fin = r_neg_q ? -rem_d : rem_d;
  assign quo_fin = q_neg_q ? -quo_d : quo_d;

`ifdef DIV_EARLY_OUT_EN
  logic              early;
  logic [WIDTH-1:0]  eo_quo;
  logic [WIDTH-1:0]  eo_hi;
  logic [WIDTH-1:0]  eo_lo;
  assign early  = (b == '0) | (a_mag < b_mag);
  assign eo_quo = (b == '0) ? '1 : '0;
  assign eo_hi  = r_neg_in ? -a_mag : a_mag;
  assign eo_lo  = q_neg_in ? -eo_quo : eo_quo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      bmag_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (cancel) begin
        state_q <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            state_q <= S_IDLE;
            if (start) begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              bmag_q  <= {1'b0, b_mag};
              q_neg_q <= q_neg_in;
              r_neg_q <= r_neg_in;
              dz_q    <= (b == '0);
              cnt_q   <= '0;
`ifdef DIV_EARLY_OUT_EN
              if (early) begin
                state_q  <= S_DONE;
                ready    <= 1'b1;
                result   <= {eo_hi, eo_lo};
                div_zero <= (b == '0);
              end else begin
                state_q <= S_DIV;
                busy    <= 1'b1;
              end
`else
              state_q <= S_DIV;
              busy    <= 1'b1;
`endif
            end
          end
          S_DIV: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
              state_q  <= S_DONE;
              busy     <= 1'b0;
              ready    <= 1'b1;
              result   <= {rem_fin, quo_fin};
              div_zero <= dz_q;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus random operands vs. an arithmetic model.
module tb_div_iter;

  localparam int unsigned W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           cancel;
  logic           busy;
  logic           ready;
  logic [2*W-1:0] result;
  logic           div_zero;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .ready(ready),
    .result(result), .div_zero(div_zero)
  );

  // Reference: language division truncates toward zero, matching DIV/DIVU semantics
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    logic [31:0] hi, lo;
    if (y == 32'd0) begin
      hi = x;
      lo = (s && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
    end else begin
      sx = s ? longint'($signed(x)) : longint'({32'd0, x});
      sy = s ? longint'($signed(y)) : longint'({32'd0, y});
      q  = sx / sy;
      r  = sx % sy;
      hi = r[31:0];
      lo = q[31:0];
    end
    return {hi, lo};
  endfunction

  function automatic bit ref_early(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint ax, ay;
    ax = (s && x[31]) ? -longint'($signed(x)) : longint'({32'd0, x});
    ay = (s && y[31]) ? -longint'($signed(y)) : longint'({32'd0, y});
    return EO && ((y == 32'd0) || (ax < ay));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one start and watch until ready (bounded); returns latency and observations
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output int lat, output int nbusy, output logic busy_at,
                        output logic [63:0] res, output logic dz);
    start = 1'b1; a = x; b = y; signed_div = s;
    cycle();
    start = 1'b0;
    lat = -1; nbusy = 0; busy_at = 1'bx; res = 'x; dz = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k; busy_at = busy; res = result; dz = div_zero;
        break;
      end
      if (busy) nbusy++;
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    cycle(); cycle();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else n_pass++;
    n_total++; if (result !== 64'd0) $display("FAIL reset_result got %h exp 0", result); else n_pass++;
    n_total++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero got %b exp 0", div_zero); else n_pass++;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5};
    logic [31:0] tb [4] = '{32'd2, 32'd2,         32'hFFFF_FFFF, 32'd0};
    logic        ts [4] = '{1'b0,  1'b1,          1'b1,          1'b0};
    logic [63:0] te [4] = '{{32'd1, 32'd3}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                            {32'd0, 32'h8000_0000}, {32'd5, 32'hFFFF_FFFF}};
    int lat, nb, elat, enb;
    logic ba, dz;
    logic [63:0] res;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], ts[i], lat, nb, ba, res, dz);
      elat = ref_early(ta[i], tb[i], ts[i]) ? 1 : 33;
      enb  = (elat == 1) ? 0 : 32;
      n_total++; if (lat !== elat) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, elat); else n_pass++;
      n_total++; if (nb !== enb) $display("FAIL dir%0d_busy_cycles got %0d exp %0d", i, nb, enb); else n_pass++;
      n_total++; if (ba !== 1'b0) $display("FAIL dir%0d_busy_at_ready got %b exp 0", i, ba); else n_pass++;
      n_total++; if (res !== te[i]) $display("FAIL dir%0d_result got %h exp %h", i, res, te[i]); else n_pass++;
      n_total++; if (dz !== (tb[i] == 32'd0)) $display("FAIL dir%0d_div_zero got %b exp %b", i, dz, tb[i] == 32'd0); else n_pass++;
      cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic s, ba, dz;
    logic [63:0] res, exp_res;
    int lat, nb, elat, mode;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      if (mode == 1) y = 32'($urandom_range(1, 15));
      if (mode == 2) y = 32'd0;
      if (mode == 3) x = 32'($urandom_range(0, 100));
      run_op(x, y, s, lat, nb, ba, res, dz);
      exp_res = ref_div(x, y, s);
      elat = ref_early(x, y, s) ? 1 : 33;
      n_total++; if (lat !== elat) $display("FAIL rnd%0d_latency a=%h b=%h s=%b got %0d exp %0d", i, x, y, s, lat, elat); else n_pass++;
      n_total++; if (res !== exp_res) $display("FAIL rnd%0d_result a=%h b=%h s=%b got %h exp %h", i, x, y, s, res, exp_res); else n_pass++;
      n_total++; if (dz !== (y == 32'd0)) $display("FAIL rnd%0d_div_zero got %b exp %b", i, dz, y == 32'd0); else n_pass++;
      n_total++; if (ba !== 1'b0) $display("FAIL rnd%0d_busy_at_ready got %b exp 0", i, ba); else n_pass++;
      cycle();
    end
  endtask

  task automatic test_cancel();
    int lat, nb;
    logic ba, dz;
    logic [63:0] res;
    start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 10; k++) cycle();
    cancel = 1'b1;
    cycle();
    cancel = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL cancel_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL cancel_ready got %b exp 0", ready); else n_pass++;
    run_op(32'd100, 32'd7, 1'b0, lat, nb, ba, res, dz);
    n_total++; if (lat !== 33) $display("FAIL cancel_restart_latency got %0d exp 33", lat); else n_pass++;
    n_total++; if (res !== {32'd2, 32'd14}) $display("FAIL cancel_restart_result got %h exp %h", res, {32'd2, 32'd14}); else n_pass++;
    n_total++; if (nb !== 32) $display("FAIL cancel_restart_busy_cycles got %0d exp 32", nb); else n_pass++;
    cycle();
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic ba, dz;
    logic [63:0] res, held;
    start = 1'b1; a = 32'd1000; b = 32'd3; signed_div = 1'b0;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 5; k++) cycle();
    start = 1'b1; a = 32'd9; b = 32'd4;
    cycle();
    start = 1'b0;
    lat = -1;
    for (int k = 6; k <= 60; k++) begin
      @(negedge clk);
      if (ready) begin
        lat = k; res = result;
        break;
      end
      cycle();
    end
    n_total++; if (lat !== 33) $display("FAIL ignore_latency got %0d exp 33", lat); else n_pass++;
    n_total++; if (res !== ref_div(32'd1000, 32'd3, 1'b0)) $display("FAIL ignore_result got %h exp %h", res, ref_div(32'd1000, 32'd3, 1'b0)); else n_pass++;
    // Start issued during the DONE cycle
    run_op(32'd50, 32'd6, 1'b0, lat, nb, ba, res, dz);
    n_total++; if (lat !== 33) $display("FAIL b2b_latency got %0d exp 33", lat); else n_pass++;
    n_total++; if (res !== ref_div(32'd50, 32'd6, 1'b0)) $display("FAIL b2b_result got %h exp %h", res, ref_div(32'd50, 32'd6, 1'b0)); else n_pass++;
    held = ref_div(32'd50, 32'd6, 1'b0);
    cycle();
    @(negedge clk);
    n_total++; if (ready !== 1'b0) $display("FAIL b2b_ready_pulse got %b exp 0", ready); else n_pass++;
    n_total++; if (result !== held) $display("FAIL b2b_result_hold got %h exp %h", result, held); else n_pass++;
    cycle();
  endtask

  task automatic test_rst_mid();
    int nready;
    start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
    cycle();
    start = 1'b0;
    for (int k = 1; k < 20; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rstmid_ready got %b exp 0", ready); else n_pass++;
    n_total++; if (result !== 64'd0) $display("FAIL rstmid_result got %h exp 0", result); else n_pass++;
    nready = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      @(negedge clk);
      if (ready) nready++;
    end
    n_total++; if (nready !== 0) $display("FAIL rstmid_no_ready got %0d exp 0", nready); else n_pass++;
    cycle();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider for the execute stage. It consumes DIV/DIVU operations selected by the main decoder; those operations assert both HI and LO writes. It produces a 64-bit {remainder, quotient} pair for the HI/LO register write. While it works, it holds the pipeline through `busy`. One quotient bit is resolved per cycle, and an in-flight operation can be cancelled on exception or flush.

## Interface
- `WIDTH`, 32: operand width; `result` is 2*WIDTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request, sampled with operands.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `a` in WIDTH: dividend (rs).
- `b` in WIDTH: divisor (rt).
- `cancel` in 1: abort the in-flight operation (exception or flush).
- `busy` out 1: iterations in progress; the pipeline stalls on `start | busy`.
- `ready` out 1: one-cycle pulse; `result` is valid.
- `result` out 2*WIDTH: {hi = remainder, lo = quotient}.
- `div_zero` out 1: divisor was zero; valid with `ready`.

## Operation
- States:
  - IDLE: wait for `start`.
  - DIV: iterate.
  - DONE: assert `ready` for one cycle.
- Accept rule:
  - `start` is accepted in IDLE or DONE when `cancel` = 0.
  - `start` in DIV is ignored.
- On accept, the block latches:
  - the operand magnitudes (abs if `signed_div`, raw otherwise);
  - `q_neg` = signed & (a[31] ^ b[31]);
  - `r_neg` = signed & a[31];
  - `div_zero` = (b == 0).
  - It also clears the partial remainder and sets the 6-bit counter to 0.
- DIV iteration:
  - Shift {rem, quo} left 1 and trial-subtract |b| from the upper 33 bits.
  - If the difference is non-negative, keep it and set quo[0] = 1; otherwise set quo[0] = 0.
  - Increment the counter. After iteration 31, go to DONE.
- DONE:
  - `result` = {r_neg ? -rem : rem, q_neg ? -quo : quo}.
  - Return to IDLE next cycle unless a new `start` is accepted.
- Arithmetic rules:
  - Magnitudes are WIDTH+1 bits internally, so |0x80000000| is exact.
  - Negation is two's complement mod 2^WIDTH.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo = 0x80000000, hi = 0.
- Divide by zero runs normally:
  - quotient magnitude is all ones, remainder magnitude is |a|, then sign correction is applied.
  - `div_zero` = 1. No trap is raised; that is architecturally UNPREDICTABLE and is handled by software.
- `cancel` has priority over everything except `rst`:
  - Next state is IDLE, `busy` = 0, and no `ready` is produced.
  - `cancel` together with `start` is a rejected start.
- `rst` at any point: state IDLE, counter 0.

## Timing
- Reset values: `busy` = 0, `ready` = 0, `result` = 0, `div_zero` = 0.
- Accepted `start` in cycle 0:
  - `busy` = 1 in cycles 1–32.
  - `ready` = 1 and `busy` = 0 in cycle 33.
  - Latency is 33 cycles.
- `result` and `div_zero` are registered and hold their value until the next accepted `start` completes or `rst`.
- `ready` is never high for two consecutive cycles.
- A back-to-back `start` in the DONE cycle gives the next `ready` 33 cycles later.
- `cancel` in cycle k (k in 1–32) gives `busy` = 0 in cycle k+1 and no `ready`. A `start` in cycle k+1 is accepted.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - On accept, if `b` == 0 or |a| < |b|, skip DIV and enter DONE directly: `ready` in cycle 1, `busy` never asserted.
  - Values match the full-iteration result exactly:
    - zero divisor: quo = 0xFFFFFFFF, rem = |a|, sign-corrected;
    - |a| < |b|: quo = 0, rem = |a|, sign-corrected.
- `DIV_EARLY_OUT_EN` undefined: every accepted operation takes 33 cycles.

## Test plan
- Unsigned 7/2 at cycle 0 → `busy` high cycles 1–32; cycle 33: `ready` = 1, result = {0x00000001, 0x00000003}, `div_zero` = 0.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → hi = 0xFFFFFFFF, lo = 0xFFFFFFFD. Also signed 0x80000000 / 0xFFFFFFFF → hi = 0, lo = 0x80000000.
- Unsigned 5/0 → hi = 0x00000005, lo = 0xFFFFFFFF, `div_zero` = 1:
  - cycle 33 without `DIV_EARLY_OUT_EN`;
  - cycle 1 with it.
- Start 100/7, assert `cancel` in cycle 10 → `busy` = 0 in cycle 11, no `ready` ever. Then start 100/7 in cycle 11 → cycle 44: hi = 2, lo = 14.
- `start` pulsed again in cycle 5 with different operands → ignored; cycle 33 result reflects the first operands. A `start` in the DONE cycle is accepted, with `ready` 33 cycles later.
- `rst` asserted in cycle 20 of an operation → next cycle: `busy` = 0, `ready` = 0, `result` = 0. No `ready` appears afterwards.
